// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: active-low font,
// display source encodings and converter states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    SRC_HEX = 3'd0,
    SRC_I   = 3'd1,
    SRC_R   = 3'd2,
    SRC_J   = 3'd3,
    SRC_CLK = 3'd4
  } src_t;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  function automatic logic [6:0] font(input logic [3:0] nib);
    case (nib)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

  // Unused select codes alias to the hex source.
  function automatic src_t decode_sel(input logic [2:0] sel);
    case (sel)
      3'd1:    return SRC_I;
      3'd2:    return SRC_R;
      3'd3:    return SRC_J;
      3'd4:    return SRC_CLK;
      default: return SRC_HEX;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-stage signal bundle: CPU-side data/control in, digit drive out.
interface seg7_scan_driver_if;
  logic [31:0] hex;
  logic [10:0] cnt_i;
  logic [10:0] cnt_r;
  logic [10:0] cnt_j;
  logic [10:0] cnt_clk;
  logic [2:0]  sel;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output hex, cnt_i, cnt_r, cnt_j, cnt_clk, sel, blank_lz,
    input  an, seg, dp
  );

  modport slave (
    input  hex, cnt_i, cnt_r, cnt_j, cnt_clk, sel, blank_lz,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_driver_bin2bcd_11.sv
// Iterative double-dabble converter: one load edge on start, then eleven
// shift edges; done pulses for one cycle with the final BCD on bcd.
module bin2bcd_11
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  conv_state_t state, state_n;
  logic [10:0] sh, sh_n;
  logic [15:0] acc, acc_n, adj;
  logic [3:0]  cnt, cnt_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CONV_IDLE;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    acc_n   = acc;
    cnt_n   = cnt;
    case (state)
      CONV_IDLE, CONV_DONE: begin
        if (start) begin
          sh_n    = bin;
          acc_n   = '0;
          cnt_n   = '0;
          state_n = CONV_SHIFT;
        end else begin
          state_n = CONV_IDLE;
        end
      end
      CONV_SHIFT: begin
        {acc_n, sh_n} = {adj, sh} << 1;
        cnt_n         = cnt + 4'd1;
        if (cnt == 4'd10) state_n = CONV_DONE;
      end
      default: state_n = CONV_IDLE;
    endcase
  end

  assign busy = (state == CONV_SHIFT);
  assign done = (state == CONV_DONE);
  assign bcd  = acc;

endmodule

// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed common-anode display driver with per-frame snapshot of
// the hex word or a decimal-converted statistics counter.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 16,
  parameter int unsigned DIV_W    = 17
) (
  input logic              clk,
  input logic              reset,
  seg7_scan_driver_if.slave disp
);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [2:0]       idx;
  logic             first;
  logic             frame_start;
  src_t             src_in, src_l;
  logic             blank_l;
  logic             cnt_mode;
  logic [31:0]      dbuf;

  logic             conv_start, conv_busy, conv_done;
  logic [10:0]      conv_bin;
  logic [15:0]      conv_bcd;

  logic [7:0]       lz_mask;
  logic             lz_run;
  logic [3:0]       cur_nib;
  logic [7:0]       an_d, an_q;
  logic [6:0]       seg_d, seg_q;
  logic             dp_d, dp_q;

  assign tick        = (div == DIV_W'(SCAN_DIV - 1));
  // first is set by reset so the edge after release starts a frame even
  // though the index is already 0 and no tick has occurred.
  assign frame_start = first | (tick & (idx == 3'd7));
  assign src_in      = decode_sel(disp.sel);
  assign cnt_mode    = (src_l != SRC_HEX);
  assign conv_start  = frame_start & (src_in != SRC_HEX) & ~conv_busy;

  always_comb begin
    case (src_in)
      SRC_I:   conv_bin = disp.cnt_i;
      SRC_R:   conv_bin = disp.cnt_r;
      SRC_J:   conv_bin = disp.cnt_j;
      SRC_CLK: conv_bin = disp.cnt_clk;
      default: conv_bin = '0;
    endcase
  end

  bin2bcd_11 u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div   <= '0;
      idx   <= '0;
      first <= 1'b1;
    end else begin
      div   <= tick ? '0 : div + DIV_W'(1);
      first <= 1'b0;
      if (tick) idx <= idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_l   <= SRC_HEX;
      blank_l <= 1'b0;
      dbuf    <= '0;
    end else begin
      if (frame_start) begin
        src_l   <= src_in;
        blank_l <= disp.blank_lz;
      end
      if (frame_start && src_in == SRC_HEX)
        dbuf <= disp.hex;
      else if (conv_done)
        dbuf <= {1'b0, src_l, 12'h000, conv_bcd};
    end
  end

  // Walk from the top of the numeric field down; a digit is a leading zero
  // while every digit above it (and itself) is zero. Digit 0 is never masked.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int unsigned i = 0; i < 7; i++) begin
      if (!cnt_mode || (7 - i) <= 3) begin
        lz_run         = lz_run & (dbuf[4*(7-i) +: 4] == 4'h0);
        lz_mask[7 - i] = lz_run;
      end
    end
  end

  always_comb begin
    cur_nib = dbuf[{idx, 2'b00} +: 4];
    an_d    = ~(8'b1 << idx);
    seg_d   = font(cur_nib);
    dp_d    = 1'b1;
    if (cnt_mode) begin
      if (idx >= 3'd4 && idx <= 3'd6) seg_d = SEG_BLANK;
      if (idx == 3'd7) dp_d = 1'b0;
    end
    if (blank_l && lz_mask[idx]) seg_d = SEG_BLANK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: per-frame reference model built
// from decimal/hex digit arithmetic and the font table.
module tb_seg7_scan_driver;

  localparam int SD    = 16;
  localparam int FRAME = 8 * SD;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.SCAN_DIV(SD), .DIV_W(17)) dut (
    .clk   (clk),
    .reset (reset),
    .disp  (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_cmp = 0;
  int n_bad = 0;
  int c = -1;  // index of the last clk edge since reset release

  logic [31:0] s_hex;
  logic [10:0] s_i, s_r, s_j, s_clk;
  logic [2:0]  s_sel;
  logic        s_blz;

  // Frames start on edge 0 after release and on every edge FRAME*n-1 after.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      c <= -1;
    end else begin
      if (c + 1 == 0 || (c + 2) % FRAME == 0) begin
        s_hex <= bus.hex;
        s_i   <= bus.cnt_i;
        s_r   <= bus.cnt_r;
        s_j   <= bus.cnt_j;
        s_clk <= bus.cnt_clk;
        s_sel <= bus.sel;
        s_blz <= bus.blank_lz;
      end
      c <= c + 1;
    end
  end

  function automatic logic [15:0] model(input int k);
    int src, val, p;
    logic [6:0] s;
    logic d, blank;
    src   = (s_sel > 3'd4) ? 0 : int'(s_sel);
    d     = 1'b1;
    blank = 1'b0;
    s     = 7'h7F;
    if (src == 0) begin
      s = font_tab[(s_hex >> (4 * k)) & 32'hF];
      if (s_blz && k > 0 && (s_hex >> (4 * k)) == 0) blank = 1'b1;
    end else begin
      case (src)
        1:       val = int'(s_i);
        2:       val = int'(s_r);
        3:       val = int'(s_j);
        default: val = int'(s_clk);
      endcase
      p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
      if (k <= 3) begin
        s = font_tab[(val / p) % 10];
        if (s_blz && k > 0 && val / p == 0) blank = 1'b1;
      end else if (k < 7) begin
        blank = 1'b1;
      end else begin
        s = font_tab[src];
        d = 1'b0;
      end
    end
    if (blank) s = 7'h7F;
    return {~(8'd1 << k), s, d};
  endfunction

  task automatic wait_c(input int t);
    int guard = 0;
    if (c > t) begin
      n_bad++;
      $display("FAIL schedule: at cycle %0d, required cycle %0d already passed", c, t);
    end
    while (c < t) begin
      @(negedge clk);
      guard++;
      if (guard > 200000) begin
        $display("FAIL wait_c: cycle %0d never reached, stuck at %0d", t, c);
        $fatal(1);
      end
    end
  endtask

  task automatic set_inputs(input logic [31:0] h, input logic [10:0] ci, input logic [10:0] cr,
                            input logic [10:0] cj, input logic [10:0] cc,
                            input logic [2:0] sel, input logic blz);
    bus.hex = h; bus.cnt_i = ci; bus.cnt_r = cr; bus.cnt_j = cj; bus.cnt_clk = cc;
    bus.sel = sel; bus.blank_lz = blz;
  endtask

  task automatic next_frame(output int n);
    n = (c < 0) ? 0 : (c + 1) / FRAME + 1;
  endtask

  task automatic sample_digit(input int n, input int k, output logic [15:0] got,
                              output logic [15:0] want);
    wait_c(FRAME * n + SD * k + SD - 2);
    got  = {bus.an, bus.seg, bus.dp};
    want = model(k);
  endtask

  task automatic test_reset();
    set_inputs(32'h1234ABCD, '0, '0, '0, '0, 3'd0, 1'b0);
    #1 reset = 1'b0;
    #2;
    n_cmp++;
    if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_async: got %h/%h/%b want ff/7f/1", bus.an, bus.seg, bus.dp);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_hold: got %h/%h/%b want ff/7f/1", bus.an, bus.seg, bus.dp);
    end
    reset = 1'b1;
  endtask

  task automatic test_hex_scan();
    logic [15:0] got, want;
    wait_c(0);
    n_cmp++;
    if (bus.an !== 8'hFE) begin
      n_bad++;
      $display("FAIL scan_first_edge: an got %h want fe", bus.an);
    end
    for (int k = 0; k < 8; k++) begin
      sample_digit(0, k, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL hex_scan d%0d: got %h want %h", k, got, want);
      end
    end
    for (int k = 0; k < 8; k++) begin
      wait_c(FRAME + SD * k - 1);
      n_cmp++;
      if (bus.an !== ~(8'd1 << ((k + 7) % 8))) begin
        n_bad++;
        $display("FAIL scan_before_d%0d: an got %h want %h", k, bus.an, ~(8'd1 << ((k + 7) % 8)));
      end
      wait_c(FRAME + SD * k);
      n_cmp++;
      if (bus.an !== ~(8'd1 << k)) begin
        n_bad++;
        $display("FAIL scan_at_d%0d: an got %h want %h", k, bus.an, ~(8'd1 << k));
      end
    end
  endtask

  task automatic test_counter_max();
    logic [15:0] got, want;
    int n;
    next_frame(n);
    set_inputs(32'hDEADBEEF, 11'd2047, 11'd3, 11'd4, 11'd5, 3'd1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      sample_digit(n, k, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL counter_max d%0d: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] got, want;
    int n;
    for (int pass = 0; pass < 3; pass++) begin
      next_frame(n);
      if (pass == 0) set_inputs('0, 11'd9, 11'd5, '0, '0, 3'd2, 1'b1);
      else if (pass == 1) set_inputs('0, 11'd9, 11'd0, '0, '0, 3'd2, 1'b1);
      else set_inputs(32'h00000000, '0, '0, '0, '0, 3'd0, 1'b1);
      for (int k = 0; k < 8; k++) begin
        sample_digit(n, k, got, want);
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL lz_pass%0d d%0d: got %h want %h", pass, k, got, want);
        end
      end
    end
  endtask

  task automatic test_midframe();
    logic [15:0] got, want;
    int n;
    next_frame(n);
    set_inputs(32'h0, '0, '0, '0, '0, 3'd0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        wait_c(FRAME * n + SD * 3 + 4);
        bus.hex = 32'hFFFFFFFF;
      end
      sample_digit(n + k / 8, k % 8, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL midframe f%0d d%0d: got %h want %h", k / 8, k % 8, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [15:0] got, want;
    int n;
    next_frame(n);
    set_inputs(32'h0, '0, '0, '0, 11'd1234, 3'd4, 1'b0);
    wait_c(FRAME * n - 1 + 5);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.an, bus.seg, bus.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_conv: got %h/%h/%b want ff/7f/1", bus.an, bus.seg, bus.dp);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      sample_digit(k / 8, k % 8, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL after_reset f%0d d%0d: got %h want %h", k / 8, k % 8, got, want);
      end
    end
  endtask

  task automatic test_sel_alias();
    logic [15:0] got, want;
    int n;
    next_frame(n);
    set_inputs(32'h00000009, 11'd77, 11'd88, 11'd99, 11'd11, 3'd7, 1'b0);
    for (int k = 0; k < 8; k++) begin
      sample_digit(n, k, got, want);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL sel_alias d%0d: got %h want %h", k, got, want);
      end
    end
    n_cmp++;
    if (font_tab[9] !== 7'h10 || want[7:1] !== 7'h40) begin
      n_bad++;
      $display("FAIL sel_alias_d7: model seg %h want 40", want[7:1]);
    end
  endtask

  task automatic test_random();
    logic [15:0] got, want;
    int n;
    for (int f = 0; f < 10; f++) begin
      next_frame(n);
      set_inputs($urandom, 11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
                 11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if (f % 3 == 0) bus.hex = 32'h0000_0000 | ($urandom & 32'h0000_0FFF);
      for (int k = 0; k < 8; k++) begin
        if (k == 4)
          set_inputs($urandom, 11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom),
                     3'($urandom), 1'($urandom));
        sample_digit(n, k, got, want);
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL random f%0d d%0d: got %h want %h", f, k, got, want);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hex_scan();
    test_counter_max();
    test_lz();
    test_midframe();
    test_reset_mid_conv();
    test_sel_alias();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
